mem_arbiter: RTL and testbench

Sequential arbiter that shares the core's single-port unified memory between the instruction-fetch path and the load/store path. It sits between the fetch stage, the memory stage and the memory macro. It drives the memory with a registered request/ready handshake and performs SB/SW byte-lane steering and LB/LW sign-extension. It also guarantees fetch progress under a sustained load/store stream.

---
 rtl/mem_arbiter_pkg.sv | 31 +++
 rtl/mem_arbiter_lane.sv | 37 +++
 rtl/mem_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arbiter_pkg;

    // Arbiter FSM states (2-bit encoding).
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_IF = 2'd1,
        ST_BUSY_D  = 2'd2,
        ST_RESP    = 2'd3
    } arb_state_t;

    // Byte-enable patterns for the 4-lane memory word.
    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam logic [3:0] BE_B0   = 4'b0001;
    localparam logic [3:0] BE_B1   = 4'b0010;
    localparam logic [3:0] BE_B2   = 4'b0100;
    localparam logic [3:0] BE_B3   = 4'b1000;

    // One-hot byte enable for a byte offset within the word.
    function automatic logic [3:0] be_onehot(input logic [1:0] off);
        logic [3:0] be;
        case (off)
            2'd0:    be = BE_B0;
            2'd1:    be = BE_B1;
            2'd2:    be = BE_B2;
            default: be = BE_B3;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/mem_arbiter_lane.sv
// Combinational byte-lane steering: store-side byte enables and lane
// replication, load-side byte select with sign extension.
module mem_arbiter_lane
    import mem_arbiter_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        off,
    input  logic              byte_sel,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic [DATA_W-1:0] rdata_in,
    output logic [3:0]        be,
    output logic [DATA_W-1:0] wdata_out,
    output logic [DATA_W-1:0] rdata_out
);

    logic [7:0] ld_byte;

    // Word accesses pass straight through; byte accesses steer one lane.
    always_comb begin
        be        = BE_WORD;
        wdata_out = wdata_in;
        rdata_out = rdata_in;
        case (off)
            2'd0:    ld_byte = rdata_in[7:0];
            2'd1:    ld_byte = rdata_in[15:8];
            2'd2:    ld_byte = rdata_in[23:16];
            default: ld_byte = rdata_in[31:24];
        endcase
        if (byte_sel) begin
            be        = be_onehot(off);
            wdata_out = {4{wdata_in[7:0]}};
            rdata_out = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// Data is favoured, but a pending fetch is forced through after STARVE_MAX
// back-to-back data grants.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_sb_w,
    input  logic              d_lb_w,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_misalign,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STREAK_TOP = SW'(STARVE_MAX);

    arb_state_t        state_q, state_d;
    logic [SW-1:0]     streak_q, streak_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_ack_q, if_ack_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic              d_ack_q, d_ack_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              d_misalign_q, d_misalign_d;

    logic [3:0]        st_be;
    logic [DATA_W-1:0] st_wdata;
    logic [DATA_W-1:0] ld_rdata;
    logic [DATA_W-1:0] st_rdata_unused;
    logic [3:0]        ld_be_unused;
    logic [DATA_W-1:0] ld_wdata_unused;
    logic              unused_if_lo;

    logic d_is_byte;
    logic d_mis;
    logic fetch_win;

    assign unused_if_lo = ^if_addr[1:0];

    mem_arbiter_lane #(.DATA_W(DATA_W)) u_st_lane (
        .off       (d_addr[1:0]),
        .byte_sel  (d_sb_w),
        .wdata_in  (d_wdata),
        .rdata_in  (mem_rdata),
        .be        (st_be),
        .wdata_out (st_wdata),
        .rdata_out (st_rdata_unused)
    );

    mem_arbiter_lane #(.DATA_W(DATA_W)) u_ld_lane (
        .off       (d_addr[1:0]),
        .byte_sel  (d_lb_w),
        .wdata_in  (d_wdata),
        .rdata_in  (mem_rdata),
        .be        (ld_be_unused),
        .wdata_out (ld_wdata_unused),
        .rdata_out (ld_rdata)
    );

    // Request decode: which size applies depends on direction.
    always_comb begin
        d_is_byte = d_we ? d_sb_w : d_lb_w;
        d_mis     = d_req && !d_is_byte && (d_addr[1:0] != 2'b00);
        fetch_win = if_req && (!d_req || (streak_q == STREAK_TOP));
    end

    // Next-state, arbitration, streak tracking and output register loads.
    always_comb begin
        state_d      = state_q;
        streak_d     = streak_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_be_d     = mem_be_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_ack_d     = 1'b0;
        if_rdata_d   = if_rdata_q;
        d_ack_d      = 1'b0;
        d_rdata_d    = d_rdata_q;
        d_misalign_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (fetch_win) begin
                    state_d    = ST_BUSY_IF;
                    streak_d   = '0;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_be_d   = BE_WORD;
                    mem_addr_d = {if_addr[ADDR_W-1:2], 2'b00};
                end else if (d_req) begin
                    if (!if_req)
                        streak_d = '0;
                    else if (streak_q != STREAK_TOP)
                        streak_d = streak_q + 1'b1;
                    if (d_mis) begin
                        // Rejected without touching memory.
                        state_d      = ST_RESP;
                        d_ack_d      = 1'b1;
                        d_misalign_d = 1'b1;
                        d_rdata_d    = '0;
                    end else begin
                        state_d     = ST_BUSY_D;
                        mem_req_d   = 1'b1;
                        mem_we_d    = d_we;
                        mem_be_d    = d_we ? st_be : BE_WORD;
                        mem_addr_d  = {d_addr[ADDR_W-1:2], 2'b00};
                        mem_wdata_d = st_wdata;
                    end
                end
            end
            ST_BUSY_IF: begin
                if (mem_ready) begin
                    state_d    = ST_RESP;
                    mem_req_d  = 1'b0;
                    if_ack_d   = 1'b1;
                    if_rdata_d = mem_rdata;
                end
            end
            ST_BUSY_D: begin
                if (mem_ready) begin
                    state_d   = ST_RESP;
                    mem_req_d = 1'b0;
                    d_ack_d   = 1'b1;
                    d_rdata_d = ld_rdata;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops requests and acks at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            streak_q     <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_ack_q     <= 1'b0;
            if_rdata_q   <= '0;
            d_ack_q      <= 1'b0;
            d_rdata_q    <= '0;
            d_misalign_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            streak_q     <= streak_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_ack_q     <= if_ack_d;
            if_rdata_q   <= if_rdata_d;
            d_ack_q      <= d_ack_d;
            d_rdata_q    <= d_rdata_d;
            d_misalign_q <= d_misalign_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_be     = mem_be_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign if_ack     = if_ack_q;
    assign if_rdata   = if_rdata_q;
    assign d_ack      = d_ack_q;
    assign d_rdata    = d_rdata_q;
    assign d_misalign = d_misalign_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus randomized traffic,
// checked against a transaction-level model of arbitration and lane rules.
module tb_mem_arbiter;

    localparam int MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic        d_sb_w = 1'b0;
    logic        d_lb_w = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_misalign;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_sb_w(d_sb_w), .d_lb_w(d_lb_w),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
        .d_misalign(d_misalign),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Memory responder state shared with the main sequence.
    int          wait_n = 0;
    bit          rd_fix_en = 1'b0;
    logic [31:0] rd_fix = '0;
    logic [31:0] last_rd = '0;
    int          txn_cnt = 0;
    logic [31:0] obs_addr = '0;
    logic [31:0] obs_wdata = '0;
    logic        obs_we = 1'b0;
    logic [3:0]  obs_be = '0;

    // Memory model: latches each transaction, checks it stays stable while
    // waiting, answers after wait_n wait cycles, and toggles noise otherwise.
    initial begin : responder
        bit busy;
        int cnt;
        busy = 1'b0;
        cnt = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!mem_req) begin
                busy = 1'b0;
                mem_ready = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
            end else begin
                if (!busy) begin
                    busy = 1'b1;
                    cnt = 0;
                    txn_cnt++;
                    obs_addr = mem_addr;
                    obs_wdata = mem_wdata;
                    obs_we = mem_we;
                    obs_be = mem_be;
                    last_rd = rd_fix_en ? rd_fix : $urandom;
                end else begin
                    chk("mem_addr_stable", mem_addr, obs_addr);
                    chk("mem_we_stable", 32'(mem_we), 32'(obs_we));
                    chk("mem_be_stable", 32'(mem_be), 32'(obs_be));
                    chk("mem_wdata_stable", mem_wdata, obs_wdata);
                end
                mem_ready = (cnt == wait_n);
                mem_rdata = mem_ready ? last_rd : $urandom;
                cnt++;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Reference model.
    int          m_streak = 0;
    int          wait_fix = 0;
    logic [31:0] seq_bits = '0;
    int          seq_len = 0;

    function automatic bit d_is_byte();
        return d_we ? d_sb_w : d_lb_w;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] rd, input logic [1:0] off, input bit lb);
        int b;
        if (!lb) return rd;
        b = int'((rd >> (8 * off)) & 32'hFF);
        return (b >= 128) ? 32'(b - 256) : 32'(b);
    endfunction

    task automatic rand_if();
        if_addr = $urandom & 32'hFFFF_FFFC;
    endtask

    task automatic rand_d();
        d_we    = 1'($urandom);
        d_sb_w  = 1'($urandom);
        d_lb_w  = 1'($urandom);
        d_addr  = $urandom;
        d_wdata = $urandom;
        if (!d_is_byte() && $urandom_range(0, 3) != 0) d_addr[1:0] = 2'b00;
    endtask

    // Run requests until all are served; each served requester is re-issued
    // with fresh fields (req held high) until n requests have been issued.
    task automatic run(input int n, input bit use_if, input bit use_d, input bit rnd);
        bit pend_if, pend_d, w_if, mis, got;
        int issued, lat, exp_lat, lat_off, base_cnt;
        logic [3:0] e_be;
        pend_if = use_if;
        pend_d = use_d;
        issued = 0;
        lat_off = 0;
        seq_bits = '0;
        seq_len = 0;
        if (use_if) begin if (rnd) rand_if(); if_req = 1'b1; issued++; end
        if (use_d) begin if (rnd) rand_d(); d_req = 1'b1; issued++; end
        while (pend_if || pend_d) begin
            w_if = pend_if && (!pend_d || m_streak == MAX);
            if (w_if) m_streak = 0;
            else m_streak = pend_if ? ((m_streak < MAX) ? m_streak + 1 : MAX) : 0;
            mis = !w_if && !d_is_byte() && (d_addr[1:0] != 2'b00);
            wait_n = (wait_fix >= 0) ? wait_fix : $urandom_range(0, 3);
            exp_lat = lat_off + (mis ? 1 : 2 + wait_n);
            base_cnt = txn_cnt;
            lat = 0;
            got = 1'b0;
            while (!got && lat < 40) begin
                @(posedge clk);
                #1;
                lat++;
                chk("ack_exclusive", 32'(if_ack & d_ack), 32'd0);
                if (if_ack || d_ack) got = 1'b1;
            end
            chk("ack_seen", 32'(got), 32'd1);
            if (!got) begin
                if_req = 1'b0;
                d_req = 1'b0;
                break;
            end
            chk("grant_owner_if", 32'(if_ack), 32'(w_if));
            chk("grant_owner_d", 32'(d_ack), 32'(!w_if));
            chk("ack_latency", 32'(lat), 32'(exp_lat));
            if (seq_len < 32) seq_bits[seq_len] = if_ack;
            seq_len++;
            if (w_if) begin
                chk("if_txn_count", 32'(txn_cnt), 32'(base_cnt + 1));
                chk("if_mem_addr", obs_addr, if_addr & 32'hFFFF_FFFC);
                chk("if_mem_we", 32'(obs_we), 32'd0);
                chk("if_mem_be", 32'(obs_be), 32'hF);
                chk("if_rdata", if_rdata, last_rd);
            end else begin
                chk("d_misalign", 32'(d_misalign), 32'(mis));
                if (mis) begin
                    chk("mis_no_mem_txn", 32'(txn_cnt), 32'(base_cnt));
                end else begin
                    chk("d_txn_count", 32'(txn_cnt), 32'(base_cnt + 1));
                    chk("d_mem_addr", obs_addr, d_addr & 32'hFFFF_FFFC);
                    chk("d_mem_we", 32'(obs_we), 32'(d_we));
                    if (d_we) begin
                        e_be = d_sb_w ? 4'(1 << d_addr[1:0]) : 4'hF;
                        chk("st_mem_be", 32'(obs_be), 32'(e_be));
                        chk("st_mem_wdata", obs_wdata,
                            d_sb_w ? (d_wdata & 32'hFF) * 32'h0101_0101 : d_wdata);
                    end else begin
                        chk("ld_mem_be", 32'(obs_be), 32'hF);
                        chk("ld_rdata", d_rdata, exp_load(last_rd, d_addr[1:0], d_lb_w));
                    end
                end
            end
            if (w_if) begin
                if (issued < n) begin rand_if(); issued++; end
                else begin if_req = 1'b0; pend_if = 1'b0; end
            end else begin
                if (issued < n) begin rand_d(); issued++; end
                else begin d_req = 1'b0; pend_d = 1'b0; end
            end
            lat_off = 1;
        end
        @(posedge clk);
        #1;
        chk("ack_pulse_ends", 32'({if_ack, d_ack}), 32'd0);
    endtask

    initial begin : main
        int pat;
        bit got;
        bit stray;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_acks", 32'({if_ack, d_ack, d_misalign}), 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fetch only, zero-wait.
        wait_fix = 0;
        rd_fix_en = 1'b1;
        rd_fix = 32'h00A0_0093;
        if_addr = 32'h100;
        run(1, 1'b1, 1'b0, 1'b0);
        chk("t_fetch_addr", obs_addr, 32'h100);

        // SB at 0x203, then LB at 0x203.
        d_we = 1'b1; d_sb_w = 1'b1; d_lb_w = 1'b0;
        d_addr = 32'h203; d_wdata = 32'h5A;
        run(1, 1'b0, 1'b1, 1'b0);
        chk("t_sb_be", 32'(obs_be), 32'b1000);
        chk("t_sb_wdata", obs_wdata, 32'h5A5A_5A5A);
        chk("t_sb_addr", obs_addr, 32'h200);
        d_we = 1'b0; d_sb_w = 1'b0; d_lb_w = 1'b1;
        rd_fix = 32'h8000_0000;
        run(1, 1'b0, 1'b1, 1'b0);

        // Misaligned LW at 0x102.
        d_lb_w = 1'b0; d_addr = 32'h102;
        run(1, 1'b0, 1'b1, 1'b0);

        // Memory ready delayed by 3 wait cycles.
        wait_fix = 3;
        rd_fix = 32'h1234_5678;
        d_addr = 32'h300;
        run(1, 1'b0, 1'b1, 1'b0);

        // Both requesting continuously: 4 data, 1 fetch, 4 data, 1 fetch.
        wait_fix = 0;
        rd_fix_en = 1'b0;
        run(1, 1'b1, 1'b0, 1'b1);
        run(10, 1'b1, 1'b1, 1'b1);
        chk("t_starve_pattern", seq_bits, 32'h210);

        // Reset during the third back-to-back data access.
        if_addr = 32'h500;
        d_we = 1'b0; d_lb_w = 1'b0; d_sb_w = 1'b0; d_addr = 32'h400;
        wait_n = 0;
        if_req = 1'b1;
        d_req = 1'b1;
        for (int k = 0; k < 2; k++) begin
            got = 1'b0;
            for (int c = 0; c < 12 && !got; c++) begin
                @(posedge clk);
                #1;
                if (d_ack) got = 1'b1;
            end
            chk("rst_pre_dack", 32'(got), 32'd1);
        end
        wait_n = 20;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("rst_busy_mem_req", 32'(mem_req), 32'd1);
        chk("rst_busy_mem_addr", mem_addr, 32'h400);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_mem_req", 32'(mem_req), 32'd0);
        chk("rst_async_acks", 32'({if_ack, d_ack}), 32'd0);
        if_req = 1'b0;
        d_req = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_streak = 0;
        stray = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (d_ack || if_ack || mem_req) stray = 1'b1;
        end
        chk("rst_no_ack_after", 32'(stray), 32'd0);
        wait_fix = 0;
        run(10, 1'b1, 1'b1, 1'b1);
        chk("t_post_rst_pattern", seq_bits, 32'h210);

        // Randomized traffic with random memory latency.
        wait_fix = -1;
        for (int it = 0; it < 40; it++) begin
            pat = $urandom_range(0, 3);
            case (pat)
                0: run(1, 1'b1, 1'b0, 1'b1);
                1: run(1, 1'b0, 1'b1, 1'b1);
                2: run(2, 1'b1, 1'b1, 1'b1);
                default: run($urandom_range(3, 8), 1'b1, 1'b1, 1'b1);
            endcase
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
